// File: rtl/ddr4_rx_pkg.sv
// rtl/ddr4_rx_pkg.sv - shared types, defaults and pattern helper for the DDR4 read-lane trainer
package ddr4_rx_pkg;

  localparam int LANE_W = 8;
  localparam logic [7:0] TRAIN_PAT_DEF = 8'hB1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN_SETTLE,
    ST_SCAN_SAMPLE,
    ST_SCAN_STEP,
    ST_CENTER_LOAD,
    ST_CENTER_MOVE,
    ST_ALIGN_SETTLE,
    ST_ALIGN_SAMPLE,
    ST_ALIGN_SLIP,
    ST_DONE,
    ST_FAIL
  } train_state_e;

  typedef enum logic [1:0] {
    PACE_LOAD,
    PACE_MOVE,
    PACE_SLIP
  } pace_kind_e;

  // True when word is any of the 8 bit-rotations of pat (framing not yet known).
  function automatic logic rot_match(input logic [7:0] word, input logic [7:0] pat);
    logic [15:0] dbl;
    logic        hit;
    dbl = {pat, pat};
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dbl[i +: 8] == word) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ddr4_rx_lane_train_if.sv
// rtl/ddr4_rx_lane_train_if.sv - receive-lane IOD connection (data in, delay/slip controls out)
interface ddr4_rx_lane_train_if;

  logic [ddr4_rx_pkg::LANE_W-1:0] rx_data;
  logic                           rx_valid;
  logic                           delay_line_out_of_range;
  logic                           rx_bit_slip;
  logic                           delay_line_load;
  logic                           delay_line_move;
  logic                           delay_line_direction;

  modport master (
    output rx_data,
    output rx_valid,
    output delay_line_out_of_range,
    input  rx_bit_slip,
    input  delay_line_load,
    input  delay_line_move,
    input  delay_line_direction
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  delay_line_out_of_range,
    output rx_bit_slip,
    output delay_line_load,
    output delay_line_move,
    output delay_line_direction
  );

endinterface

// File: rtl/ddr4_rx_pulse_pacer.sv
// rtl/ddr4_rx_pulse_pacer.sv - single-cycle LOAD/MOVE/SLIP pulse generator with settle hold-off
module ddr4_rx_pulse_pacer
  import ddr4_rx_pkg::*;
#(
  parameter logic [7:0] SETTLE = 8'd4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  pace_kind_e kind,
  output logic       ready,
  output logic       load_pulse,
  output logic       move_pulse,
  output logic       dir_out,
  output logic       slip_pulse
);

  logic [7:0] cnt;

  // cnt is loaded in the pulse cycle itself, so ready only returns after SETTLE quiet cycles.
  assign ready = (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt        <= 8'd0;
      load_pulse <= 1'b0;
      move_pulse <= 1'b0;
      dir_out    <= 1'b0;
      slip_pulse <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      move_pulse <= 1'b0;
      dir_out    <= 1'b0;
      slip_pulse <= 1'b0;
      if (req && ready) begin
        cnt        <= SETTLE;
        load_pulse <= (kind == PACE_LOAD);
        move_pulse <= (kind == PACE_MOVE);
        dir_out    <= (kind == PACE_MOVE);
        slip_pulse <= (kind == PACE_SLIP);
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: rtl/ddr4_rx_lane_train.sv
// rtl/ddr4_rx_lane_train.sv - per-lane read training: eye scan, tap centring, bit-slip framing, aligned data out
module ddr4_rx_lane_train
  import ddr4_rx_pkg::*;
#(
  parameter logic [7:0] TRAIN_PAT = TRAIN_PAT_DEF,
  parameter logic [7:0] SETTLE    = 8'd4,
  parameter logic [7:0] SAMPLES   = 8'd8,
  parameter logic [7:0] MAX_TAPS  = 8'd128,
  parameter logic [7:0] MIN_EYE   = 8'd4
) (
  input  logic              fab_clk,
  input  logic              rx_sync_rst_n,
  input  logic              train_start,
  ddr4_rx_lane_train_if.slave iod,
  output logic              train_done,
  output logic              train_fail,
  output logic [7:0]        eye_start,
  output logic [7:0]        eye_width,
  output logic [7:0]        tap_pos,
  output logic [LANE_W-1:0] data_out,
  output logic              data_valid
);

  localparam logic [7:0] LAST_TAP = MAX_TAPS - 8'd1;

  train_state_e state;
  logic [7:0]   samp_cnt;
  logic         word_ok;
  logic [7:0]   run_start;
  logic [7:0]   run_len;
  logic [7:0]   moves_left;
  logic [3:0]   slip_cnt;

  logic         pace_req;
  pace_kind_e   pace_kind;
  logic         pace_ready;

  logic         last_sample;
  logic         rot_ok;
  logic         exact_ok;
  logic         scan_end;
  logic         run_wins;
  logic [7:0]   best_start;
  logic [7:0]   best_width;
  logic         restart;

  assign last_sample = iod.rx_valid && (samp_cnt == SAMPLES - 8'd1);
  assign rot_ok      = rot_match(iod.rx_data, TRAIN_PAT);
  assign exact_ok    = (iod.rx_data == TRAIN_PAT);
  assign scan_end    = (tap_pos == LAST_TAP) || iod.delay_line_out_of_range;
  assign restart     = train_start &&
                       ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));

  // Strictly longer replaces the stored eye, so the earlier run survives a tie.
  assign run_wins    = (run_len > eye_width);
  assign best_start  = run_wins ? run_start : eye_start;
  assign best_width  = run_wins ? run_len : eye_width;

  always_comb begin
    pace_req  = 1'b0;
    pace_kind = PACE_MOVE;
    case (state)
      ST_LOAD, ST_CENTER_LOAD: begin
        pace_req  = 1'b1;
        pace_kind = PACE_LOAD;
      end
      ST_SCAN_STEP:   pace_req = !scan_end;
      ST_CENTER_MOVE: pace_req = pace_ready && !iod.delay_line_out_of_range &&
                                 (moves_left != 8'd0);
      ST_ALIGN_SLIP: begin
        pace_req  = 1'b1;
        pace_kind = PACE_SLIP;
      end
      default: ;
    endcase
  end

  ddr4_rx_pulse_pacer #(
    .SETTLE(SETTLE)
  ) u_pacer (
    .clk       (fab_clk),
    .resetn    (rx_sync_rst_n),
    .req       (pace_req),
    .kind      (pace_kind),
    .ready     (pace_ready),
    .load_pulse(iod.delay_line_load),
    .move_pulse(iod.delay_line_move),
    .dir_out   (iod.delay_line_direction),
    .slip_pulse(iod.rx_bit_slip)
  );

  always_ff @(posedge fab_clk) begin
    if (!rx_sync_rst_n) begin
      state      <= ST_IDLE;
      samp_cnt   <= 8'd0;
      word_ok    <= 1'b0;
      run_start  <= 8'd0;
      run_len    <= 8'd0;
      moves_left <= 8'd0;
      slip_cnt   <= 4'd0;
      train_done <= 1'b0;
      train_fail <= 1'b0;
      eye_start  <= 8'd0;
      eye_width  <= 8'd0;
      tap_pos    <= 8'd0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (restart) begin
        train_done <= 1'b0;
        train_fail <= 1'b0;
        state      <= ST_LOAD;
      end
      case (state)
        ST_LOAD: begin
          tap_pos   <= 8'd0;
          eye_start <= 8'd0;
          eye_width <= 8'd0;
          run_start <= 8'd0;
          run_len   <= 8'd0;
          slip_cnt  <= 4'd0;
          state     <= ST_SCAN_SETTLE;
        end
        ST_SCAN_SETTLE: begin
          samp_cnt <= 8'd0;
          word_ok  <= 1'b1;
          if (pace_ready) state <= ST_SCAN_SAMPLE;
        end
        ST_SCAN_SAMPLE: begin
          if (last_sample) begin
            state <= ST_SCAN_STEP;
            if (word_ok && rot_ok) begin
              if (run_len == 8'd0) run_start <= tap_pos;
              if (run_len != 8'hFF) run_len <= run_len + 8'd1;
            end else begin
              eye_start <= best_start;
              eye_width <= best_width;
              run_len   <= 8'd0;
            end
          end else if (iod.rx_valid) begin
            samp_cnt <= samp_cnt + 8'd1;
            word_ok  <= word_ok && rot_ok;
          end
        end
        ST_SCAN_STEP: begin
          if (scan_end) begin
            // Close whatever run is still open at the last scanned tap.
            eye_start <= best_start;
            eye_width <= best_width;
            run_len   <= 8'd0;
            if (best_width < MIN_EYE) begin
              train_fail <= 1'b1;
              state      <= ST_FAIL;
            end else begin
              state <= ST_CENTER_LOAD;
            end
          end else begin
            tap_pos <= tap_pos + 8'd1;
            state   <= ST_SCAN_SETTLE;
          end
        end
        ST_CENTER_LOAD: begin
          tap_pos    <= 8'd0;
          moves_left <= eye_start + (eye_width >> 1);
          state      <= ST_CENTER_MOVE;
        end
        ST_CENTER_MOVE: begin
          // Range flag is only trusted once the previous pulse has settled.
          if (pace_ready) begin
            if (iod.delay_line_out_of_range) begin
              train_fail <= 1'b1;
              state      <= ST_FAIL;
            end else if (moves_left != 8'd0) begin
              moves_left <= moves_left - 8'd1;
              tap_pos    <= tap_pos + 8'd1;
            end else begin
              state <= ST_ALIGN_SETTLE;
            end
          end
        end
        ST_ALIGN_SETTLE: begin
          samp_cnt <= 8'd0;
          word_ok  <= 1'b1;
          if (pace_ready) state <= ST_ALIGN_SAMPLE;
        end
        ST_ALIGN_SAMPLE: begin
          if (last_sample) begin
            if (word_ok && exact_ok) begin
              train_done <= 1'b1;
              state      <= ST_DONE;
            end else if (slip_cnt == 4'd8) begin
              train_fail <= 1'b1;
              state      <= ST_FAIL;
            end else begin
              state <= ST_ALIGN_SLIP;
            end
          end else if (iod.rx_valid) begin
            samp_cnt <= samp_cnt + 8'd1;
            word_ok  <= word_ok && exact_ok;
          end
        end
        ST_ALIGN_SLIP: begin
          slip_cnt <= slip_cnt + 4'd1;
          state    <= ST_ALIGN_SETTLE;
        end
        ST_DONE: begin
          data_out   <= iod.rx_data;
          data_valid <= iod.rx_valid && !restart;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr4_rx_lane_train.sv
// tb/tb_ddr4_rx_lane_train.sv - directed bench with a behavioural IOD lane model
module tb_ddr4_rx_lane_train;
  import ddr4_rx_pkg::*;

  localparam logic [7:0] TP     = 8'hB1;
  localparam int         BUDGET = 20000;

  logic       fab_clk = 1'b0;
  logic       rx_sync_rst_n;
  logic       train_start;
  logic       train_done, train_fail, data_valid;
  logic [7:0] eye_start, eye_width, tap_pos, data_out;

  ddr4_rx_lane_train_if ifc ();

  ddr4_rx_lane_train dut (
    .fab_clk      (fab_clk),
    .rx_sync_rst_n(rx_sync_rst_n),
    .train_start  (train_start),
    .iod          (ifc),
    .train_done   (train_done),
    .train_fail   (train_fail),
    .eye_start    (eye_start),
    .eye_width    (eye_width),
    .tap_pos      (tap_pos),
    .data_out     (data_out),
    .data_valid   (data_valid)
  );

  always #5 fab_clk = ~fab_clk;

  int checks = 0;
  int errors = 0;
  int cycles_full = 0;

  int win_lo = 300, win_hi = 300, win2_lo = 300, win2_hi = 300;
  int oor_at = 1000, rot0 = 0, slip_base = 0;
  bit slip_ignored = 1'b0, half_valid = 1'b0;
  bit force_en = 1'b0, vforce_en = 1'b0, vforce = 1'b0;
  logic [7:0] force_data = 8'h00;

  logic [7:0] m_tap = 8'd0;
  logic       valid_ph = 1'b0;
  logic       prev_any = 1'b0;
  int load_count = 0, move_count = 0, slip_count = 0, viol = 0;

  // IOD model: tap follows LOAD/MOVE, framing follows BIT_SLIP; pulse rules are monitored.
  always @(posedge fab_clk) begin
    if (ifc.delay_line_load) begin
      m_tap      <= 8'd0;
      load_count <= load_count + 1;
    end else if (ifc.delay_line_move) begin
      if (ifc.delay_line_direction) m_tap <= m_tap + 8'd1;
      move_count <= move_count + 1;
    end
    if (ifc.rx_bit_slip) slip_count <= slip_count + 1;
    if (($countones({ifc.delay_line_load, ifc.delay_line_move, ifc.rx_bit_slip}) > 1) ||
        (prev_any && (ifc.delay_line_load || ifc.delay_line_move || ifc.rx_bit_slip)) ||
        (ifc.delay_line_move && !ifc.delay_line_direction))
      viol <= viol + 1;
    prev_any <= ifc.delay_line_load || ifc.delay_line_move || ifc.rx_bit_slip;
    valid_ph <= ~valid_ph;
  end

  logic [15:0] pat_dbl;
  logic [2:0]  cur_rot;
  logic        in_win;
  assign pat_dbl = {TP, TP};
  assign cur_rot = slip_ignored ? 3'(rot0) : 3'(rot0 + slip_count - slip_base);
  assign in_win  = ((int'(m_tap) >= win_lo) && (int'(m_tap) <= win_hi)) ||
                   ((int'(m_tap) >= win2_lo) && (int'(m_tap) <= win2_hi));
  assign ifc.rx_data  = force_en ? force_data : (in_win ? pat_dbl[cur_rot +: 8] : 8'h00);
  assign ifc.rx_valid = vforce_en ? vforce : (half_valid ? valid_ph : 1'b1);
  assign ifc.delay_line_out_of_range = (int'(m_tap) >= oor_at);

  task automatic set_env(input int lo, input int hi, input int lo2, input int hi2,
                         input int oor, input int rot, input bit ign, input bit half);
    win_lo = lo; win_hi = hi; win2_lo = lo2; win2_hi = hi2;
    oor_at = oor; rot0 = rot; slip_ignored = ign; half_valid = half;
    slip_base = slip_count;
  endtask

  task automatic run_train(output int cycles);
    @(negedge fab_clk); train_start = 1'b1;
    @(negedge fab_clk); train_start = 1'b0;
    cycles = 1;
    while (!(train_done || train_fail) && cycles < BUDGET) begin
      @(negedge fab_clk);
      cycles++;
    end
    checks++;
    if (cycles >= BUDGET) begin
      errors++;
      $display("FAIL train_timeout: done=%0b fail=%0b after %0d cycles, required done or fail",
               train_done, train_fail, cycles);
    end
  endtask

  task automatic test_reset();
    rx_sync_rst_n = 1'b0;
    train_start   = 1'b0;
    repeat (3) @(negedge fab_clk);
    checks++;
    if ({train_done, train_fail, data_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b required 000", {train_done, train_fail, data_valid});
    end
    checks++;
    if ({eye_start, eye_width, tap_pos, data_out} !== 32'h0) begin
      errors++; $display("FAIL reset_regs: got %h required 0", {eye_start, eye_width, tap_pos, data_out});
    end
    checks++;
    if ({ifc.delay_line_load, ifc.delay_line_move, ifc.delay_line_direction, ifc.rx_bit_slip} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b required 0000",
                         {ifc.delay_line_load, ifc.delay_line_move, ifc.delay_line_direction, ifc.rx_bit_slip});
    end
    rx_sync_rst_n = 1'b1;
    @(negedge fab_clk);
  endtask

  task automatic test_single_window();
    int cyc, s0;
    set_env(20, 35, 300, 300, 1000, 3, 1'b0, 1'b0);
    s0 = slip_count;
    run_train(cyc);
    cycles_full = cyc;
    checks++;
    if ({train_done, train_fail} !== 2'b10) begin
      errors++; $display("FAIL single_status: got done/fail %b required 10", {train_done, train_fail});
    end
    checks++;
    if (eye_start !== 8'd20) begin errors++; $display("FAIL single_eye_start: got %0d required 20", eye_start); end
    checks++;
    if (eye_width !== 8'd16) begin errors++; $display("FAIL single_eye_width: got %0d required 16", eye_width); end
    checks++;
    if (tap_pos !== 8'd28) begin errors++; $display("FAIL single_tap_pos: got %0d required 28", tap_pos); end
    checks++;
    if (m_tap !== 8'd28) begin errors++; $display("FAIL single_iod_tap: got %0d required 28", m_tap); end
    checks++;
    if (slip_count - s0 != 5) begin errors++; $display("FAIL single_slips: got %0d required 5", slip_count - s0); end
  endtask

  task automatic test_data_path();
    @(negedge fab_clk);
    checks++;
    if ({data_valid, data_out} !== {1'b1, TP}) begin
      errors++; $display("FAIL done_stream: got valid=%b data=%h required 1 %h", data_valid, data_out, TP);
    end
    force_en = 1'b1; force_data = 8'h3C; vforce_en = 1'b1; vforce = 1'b1;
    @(negedge fab_clk);
    checks++;
    if ({data_valid, data_out} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL done_data_3c: got valid=%b data=%h required 1 3c", data_valid, data_out);
    end
    force_data = 8'h5A; vforce = 1'b0;
    @(negedge fab_clk);
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL done_invalid: got valid=%b required 0", data_valid); end
    force_en = 1'b0; vforce_en = 1'b0;
  endtask

  task automatic test_two_windows();
    int cyc, s0;
    set_env(10, 13, 40, 49, 1000, 0, 1'b0, 1'b0);
    s0 = slip_count;
    run_train(cyc);
    checks++;
    if ({train_done, eye_start, eye_width, tap_pos} !== {1'b1, 8'd40, 8'd10, 8'd45}) begin
      errors++; $display("FAIL two_win: got done=%b start=%0d width=%0d tap=%0d required 1 40 10 45",
                         train_done, eye_start, eye_width, tap_pos);
    end
    checks++;
    if (slip_count - s0 != 0) begin errors++; $display("FAIL two_win_slips: got %0d required 0", slip_count - s0); end
  endtask

  task automatic test_tie();
    int cyc;
    set_env(10, 14, 30, 34, 1000, 0, 1'b0, 1'b0);
    run_train(cyc);
    checks++;
    if ({train_done, eye_start, eye_width, tap_pos} !== {1'b1, 8'd10, 8'd5, 8'd12}) begin
      errors++; $display("FAIL tie_keep_first: got done=%b start=%0d width=%0d tap=%0d required 1 10 5 12",
                         train_done, eye_start, eye_width, tap_pos);
    end
  endtask

  task automatic test_min_eye();
    int cyc;
    set_env(20, 22, 300, 300, 1000, 0, 1'b0, 1'b0);
    run_train(cyc);
    checks++;
    if ({train_fail, train_done, eye_start, eye_width, tap_pos} !== {2'b10, 8'd20, 8'd3, 8'd127}) begin
      errors++; $display("FAIL eye_3_taps: got fail=%b done=%b start=%0d width=%0d tap=%0d required 1 0 20 3 127",
                         train_fail, train_done, eye_start, eye_width, tap_pos);
    end
    set_env(20, 23, 300, 300, 1000, 0, 1'b0, 1'b0);
    run_train(cyc);
    checks++;
    if ({train_done, train_fail, eye_width, tap_pos} !== {2'b10, 8'd4, 8'd22}) begin
      errors++; $display("FAIL eye_4_taps: got done=%b fail=%b width=%0d tap=%0d required 1 0 4 22",
                         train_done, train_fail, eye_width, tap_pos);
    end
  endtask

  task automatic test_out_of_range();
    int cyc, s0;
    set_env(300, 300, 300, 300, 90, 0, 1'b0, 1'b0);
    s0 = slip_count;
    run_train(cyc);
    checks++;
    if ({train_fail, train_done, tap_pos, eye_width} !== {2'b10, 8'd90, 8'd0}) begin
      errors++; $display("FAIL oor_stop: got fail=%b done=%b tap=%0d width=%0d required 1 0 90 0",
                         train_fail, train_done, tap_pos, eye_width);
    end
    checks++;
    if (slip_count - s0 != 0) begin errors++; $display("FAIL oor_slips: got %0d required 0", slip_count - s0); end
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL oor_valid: got %b required 0", data_valid); end
  endtask

  task automatic test_never_match();
    int cyc, s0;
    set_env(20, 35, 300, 300, 1000, 2, 1'b1, 1'b0);
    s0 = slip_count;
    run_train(cyc);
    checks++;
    if ({train_fail, train_done, eye_start, eye_width, tap_pos} !== {2'b10, 8'd20, 8'd16, 8'd28}) begin
      errors++; $display("FAIL nomatch_status: got fail=%b done=%b start=%0d width=%0d tap=%0d required 1 0 20 16 28",
                         train_fail, train_done, eye_start, eye_width, tap_pos);
    end
    checks++;
    if (slip_count - s0 != 8) begin errors++; $display("FAIL nomatch_slips: got %0d required 8", slip_count - s0); end
  endtask

  task automatic test_half_valid();
    int cyc, s0;
    set_env(20, 35, 300, 300, 1000, 3, 1'b0, 1'b1);
    s0 = slip_count;
    run_train(cyc);
    checks++;
    if ({train_done, eye_start, eye_width, tap_pos} !== {1'b1, 8'd20, 8'd16, 8'd28}) begin
      errors++; $display("FAIL half_result: got done=%b start=%0d width=%0d tap=%0d required 1 20 16 28",
                         train_done, eye_start, eye_width, tap_pos);
    end
    checks++;
    if (slip_count - s0 != 5) begin errors++; $display("FAIL half_slips: got %0d required 5", slip_count - s0); end
    checks++;
    if (cyc <= cycles_full + cycles_full / 4) begin
      errors++; $display("FAIL half_duration: got %0d cycles required more than %0d", cyc, cycles_full + cycles_full / 4);
    end
    half_valid = 1'b0;
  endtask

  task automatic test_reset_mid_center();
    int n, lb, mb, pulses;
    set_env(20, 35, 300, 300, 1000, 0, 1'b0, 1'b0);
    lb = load_count;
    @(negedge fab_clk); train_start = 1'b1;
    @(negedge fab_clk); train_start = 1'b0;
    n = 0;
    while ((load_count - lb) < 2 && n < BUDGET) begin @(negedge fab_clk); n++; end
    mb = move_count;
    while ((move_count - mb) < 3 && n < BUDGET) begin @(negedge fab_clk); n++; end
    checks++;
    if (n >= BUDGET) begin errors++; $display("FAIL center_reach: timed out after %0d cycles", n); end
    rx_sync_rst_n = 1'b0;
    @(negedge fab_clk);
    checks++;
    if ({train_done, train_fail, data_valid, eye_start, eye_width, tap_pos, data_out} !== 35'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h required 0",
                         {train_done, train_fail, data_valid, eye_start, eye_width, tap_pos, data_out});
    end
    checks++;
    if ({ifc.delay_line_load, ifc.delay_line_move, ifc.delay_line_direction, ifc.rx_bit_slip} !== 4'b0) begin
      errors++; $display("FAIL midreset_pulses: got %b required 0000",
                         {ifc.delay_line_load, ifc.delay_line_move, ifc.delay_line_direction, ifc.rx_bit_slip});
    end
    rx_sync_rst_n = 1'b1;
    pulses = load_count + move_count + slip_count;
    repeat (200) @(negedge fab_clk);
    checks++;
    if (load_count + move_count + slip_count != pulses || train_done || train_fail) begin
      errors++; $display("FAIL midreset_quiet: got %0d extra pulses done=%b fail=%b required 0 0 0",
                         load_count + move_count + slip_count - pulses, train_done, train_fail);
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL pulse_rules: got %0d violations required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_data_path();
    test_two_windows();
    test_tie();
    test_min_eye();
    test_out_of_range();
    test_never_match();
    test_half_valid();
    test_reset_mid_center();
    test_pulse_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
